// File: rtl/branch_resolver_pkg.sv
// Shared encodings for the branch resolver: request opcodes, FSM states and default width.
package branch_resolver_pkg;
  localparam int DEF_W = 16;

  typedef enum logic [1:0] {
    OP_NOP = 2'b00,
    OP_BEQ = 2'b01,
    OP_BNE = 2'b10,
    OP_JMP = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_RESOLVE = 3'd3,
    ST_FLUSH   = 3'd4
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/branch_target_adder.sv
// Branch target: pc + signed offset, wrapping modulo 2^W with no overflow indication.
module branch_target_adder #(
  parameter int W = 16
) (
  input  logic [W-1:0] pc_i,
  input  logic [W-1:0] off_i,
  output logic [W-1:0] target_o
);
  // Two's-complement offset makes a plain W-bit add the correct signed wrap.
  assign target_o = pc_i + off_i;
endmodule

// File: rtl/branch_resolver.sv
// Branch resolver: issues compares to a registered comparator, then redirects the PC
// and flushes younger stages on a taken branch or jump. All outputs are registered.
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int W         = DEF_W,
  parameter int CMP_LAT   = 1,
  parameter int FLUSH_CYC = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [1:0]   req_op,
  input  logic [W-1:0] req_a,
  input  logic [W-1:0] req_b,
  input  logic [W-1:0] req_pc,
  input  logic [W-1:0] req_off,
  output logic [W-1:0] cmp_a,
  output logic [W-1:0] cmp_b,
  output logic         cmp_eq,
  output logic         cmp_nq,
  input  logic [W-1:0] cmp_r,
  output logic         pc_load,
  output logic [W-1:0] pc_next,
  output logic         flush,
  output logic         busy
);
  localparam int CNT_W = $clog2(max_int(CMP_LAT, FLUSH_CYC) + 1);

  state_e         state_q, state_d;
  op_e            op_q, op_d;
  logic [W-1:0]   pc_q, pc_d, off_q, off_d;
  logic [W-1:0]   cmp_a_q, cmp_a_d, cmp_b_q, cmp_b_d;
  logic           cmp_eq_q, cmp_eq_d, cmp_nq_q, cmp_nq_d;
  logic           pc_load_q, pc_load_d, flush_q, flush_d;
  logic [W-1:0]   pc_next_q, pc_next_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]   target;
  op_e            req_op_e;
  logic           unused_cmp_hi;

  assign req_op_e      = op_e'(req_op);
  assign unused_cmp_hi = ^cmp_r[W-1:1];

  branch_target_adder #(.W(W)) u_target_adder (
    .pc_i     (pc_q),
    .off_i    (off_q),
    .target_o (target)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    pc_d      = pc_q;
    off_d     = off_q;
    cmp_a_d   = cmp_a_q;
    cmp_b_d   = cmp_b_q;
    cmp_eq_d  = 1'b0;
    cmp_nq_d  = 1'b0;
    pc_load_d = 1'b0;
    pc_next_d = pc_next_q;
    flush_d   = 1'b0;
    cnt_d     = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          case (req_op_e)
            OP_BEQ, OP_BNE: begin
              op_d     = req_op_e;
              pc_d     = req_pc;
              off_d    = req_off;
              cmp_a_d  = req_a;
              cmp_b_d  = req_b;
              cmp_eq_d = (req_op_e == OP_BEQ);
              cmp_nq_d = (req_op_e == OP_BNE);
              state_d  = ST_ISSUE;
            end
            OP_JMP: begin
              op_d    = req_op_e;
              pc_d    = req_pc;
              off_d   = req_off;
              state_d = ST_RESOLVE;
            end
            default: ;
          endcase
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == CNT_W'(CMP_LAT - 1)) begin
          cnt_d   = '0;
          state_d = ST_RESOLVE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESOLVE: begin
        // Only bit 0 of the comparator result carries the outcome.
        if (op_q == OP_JMP || cmp_r[0]) begin
          pc_load_d = 1'b1;
          pc_next_d = target;
          cnt_d     = '0;
          state_d   = ST_FLUSH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        // First FLUSH cycle carries pc_load; flush follows for FLUSH_CYC cycles.
        if (cnt_q == CNT_W'(FLUSH_CYC)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          flush_d = 1'b1;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_NOP;
      pc_q      <= '0;
      off_q     <= '0;
      cmp_a_q   <= '0;
      cmp_b_q   <= '0;
      cmp_eq_q  <= 1'b0;
      cmp_nq_q  <= 1'b0;
      pc_load_q <= 1'b0;
      pc_next_q <= '0;
      flush_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      pc_q      <= pc_d;
      off_q     <= off_d;
      cmp_a_q   <= cmp_a_d;
      cmp_b_q   <= cmp_b_d;
      cmp_eq_q  <= cmp_eq_d;
      cmp_nq_q  <= cmp_nq_d;
      pc_load_q <= pc_load_d;
      pc_next_q <= pc_next_d;
      flush_q   <= flush_d;
      cnt_q     <= cnt_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign cmp_a     = cmp_a_q;
  assign cmp_b     = cmp_b_q;
  assign cmp_eq    = cmp_eq_q;
  assign cmp_nq    = cmp_nq_q;
  assign pc_load   = pc_load_q;
  assign pc_next   = pc_next_q;
  assign flush     = flush_q;
endmodule
